// File: rtl/reduce_classifier.sv
// Final ECG transformer stage: mean-pools the token matrix, runs the
// linear head one MAC per cycle and reports the argmax class index.
module reduce_classifier #(
   parameter int DATA_WIDTH = 8,
   parameter int N_TOK      = 16,
   parameter int D_MODEL    = 16,
   parameter int N_CLASS    = 6,
   parameter int ACC_WIDTH  = 24
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] mat_in [N_TOK][D_MODEL],
   input  logic signed [DATA_WIDTH-1:0] cls_wt [N_CLASS*D_MODEL],
   input  logic signed [DATA_WIDTH-1:0] cls_bs [N_CLASS],
   output logic [3:0]                   classifier,
   output logic                         done,
   output logic                         busy
);

   localparam int TW = $clog2(N_TOK);
   localparam int SW = DATA_WIDTH + TW;
   localparam int DW = $clog2(D_MODEL);
   localparam int CW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;
   localparam int PW = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RED,
      S_CLS,
      S_FIN
   } state_t;

   state_t state_q, state_d;

   logic [TW-1:0]              row_q;
   logic [DW-1:0]              dim_q;
   logic [CW-1:0]              cls_q;
   logic signed [SW-1:0]       sum_q [D_MODEL];
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] best_q;
   logic [3:0]                 best_idx_q;

   logic                        last_row;
   logic                        last_dim;
   logic                        last_cls;
   logic signed [DATA_WIDTH-1:0] feat;
   logic signed [DATA_WIDTH-1:0] wt;
   logic signed [DATA_WIDTH-1:0] bias;
   logic signed [PW-1:0]        prod;
   logic signed [ACC_WIDTH-1:0] prod_x;
   logic signed [ACC_WIDTH-1:0] acc_base;
   logic signed [ACC_WIDTH-1:0] mac;
   logic                        take;

   assign last_row = (row_q == TW'(N_TOK - 1));
   assign last_dim = (dim_q == DW'(D_MODEL - 1));
   assign last_cls = (cls_q == CW'(N_CLASS - 1));

   // Upper bits of the column sum are the floor mean (arithmetic >>> TW).
   assign feat = sum_q[dim_q][SW-1:TW];
   assign wt   = cls_wt[{cls_q, dim_q}];
   assign bias = cls_bs[cls_q];
   assign prod = feat * wt;
   assign prod_x = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
   assign acc_base = (dim_q == '0)
      ? {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias}
      : acc_q;
   assign mac = acc_base + prod_x;
   // Strict compare keeps the lowest index on ties.
   assign take = last_dim && ((cls_q == '0) || (mac > best_q));

   assign done = (state_q == S_FIN);
   assign busy = (state_q != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_RED;
         S_RED:  if (last_row) state_d = S_CLS;
         S_CLS:  if (last_dim && last_cls) state_d = S_FIN;
         S_FIN:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q      <= '0;
         dim_q      <= '0;
         cls_q      <= '0;
         acc_q      <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         classifier <= '0;
         for (int d = 0; d < D_MODEL; d++) sum_q[d] <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  row_q <= '0;
                  dim_q <= '0;
                  cls_q <= '0;
                  for (int d = 0; d < D_MODEL; d++) sum_q[d] <= '0;
               end
            end
            S_RED: begin
               for (int d = 0; d < D_MODEL; d++)
                  sum_q[d] <= sum_q[d] + {{TW{mat_in[row_q][d][DATA_WIDTH-1]}},
                                          mat_in[row_q][d]};
               row_q <= row_q + 1'b1;
            end
            S_CLS: begin
               acc_q <= mac;
               dim_q <= dim_q + 1'b1;
               if (last_dim) cls_q <= cls_q + 1'b1;
               if (take) begin
                  best_q     <= mac;
                  best_idx_q <= 4'(cls_q);
               end
               if (last_dim && last_cls)
                  classifier <= take ? 4'(cls_q) : best_idx_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reduce_classifier.sv
// Directed bench for reduce_classifier: latency, argmax, ties,
// floor mean, start-while-busy and mid-run reset.
module tb_reduce_classifier;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic signed [7:0] mat_in [16][16];
   logic signed [7:0] cls_wt [96];
   logic signed [7:0] cls_bs [6];
   logic [3:0]        classifier;
   logic              done;
   logic              busy;

   int n_vec = 0;
   int n_bad = 0;
   int cyc;

   always #5 clk = ~clk;

   reduce_classifier dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mat_in     (mat_in),
      .cls_wt     (cls_wt),
      .cls_bs     (cls_bs),
      .classifier (classifier),
      .done       (done),
      .busy       (busy)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic fill_mat(input int v);
      for (int r = 0; r < 16; r++)
         for (int d = 0; d < 16; d++) mat_in[r][d] = 8'(v);
   endtask

   task automatic fill_wt(input int v);
      for (int i = 0; i < 96; i++) cls_wt[i] = 8'(v);
   endtask

   task automatic fill_bs(input int v);
      for (int i = 0; i < 6; i++) cls_bs[i] = 8'(v);
   endtask

   // Start in cycle 0; optional extra start pulses at pulse_at/again_at.
   task automatic run(input string tag, input int exp_cls, input int prev_cls,
                      input int pulse_at, input int again_at);
      int first, second, n, limit;
      first = -1;
      second = -1;
      n = 0;
      limit = (again_at >= 0) ? 240 : 120;
      cyc = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (cyc < limit) begin
         if (cyc == 1) begin
            chk({tag, "_busy1"}, int'(busy), 1);
            chk({tag, "_hold"}, int'(classifier), prev_cls);
         end
         if (cyc == 114) chk({tag, "_busy114"}, int'(busy), 0);
         if (done) begin
            n++;
            if (first < 0) begin
               first = cyc;
               chk({tag, "_cls"}, int'(classifier), exp_cls);
               chk({tag, "_busydn"}, int'(busy), 1);
            end else if (second < 0) begin
               second = cyc;
            end
         end
         start = (cyc == pulse_at || cyc == again_at);
         tick();
      end
      start = 1'b0;
      chk({tag, "_done_cyc"}, first, 113);
      chk({tag, "_done_n"}, n, (again_at >= 0) ? 2 : 1);
      if (again_at >= 0) chk({tag, "_done2_cyc"}, second, again_at + 113);
      chk({tag, "_cls_after"}, int'(classifier), exp_cls);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      start = 1'b0;
      fill_mat(0);
      fill_wt(0);
      fill_bs(0);
      #1;
      chk("rst_cls", int'(classifier), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // T1: bias alone picks class 2
      cls_bs[2] = 8'sd5;
      run("t1", 2, 0, -1, -1);

      // T2: six-way tie resolves to class 0
      fill_bs(0);
      run("t2", 0, 2, -1, -1);

      // T3: feat=-1, class 3 weights -1 -> logit 16
      fill_mat(-1);
      fill_wt(0);
      for (int d = 0; d < 16; d++) cls_wt[3*16+d] = -8'sd1;
      run("t3", 3, 0, -1, -1);

      // T4: large magnitude, logit5 = 258191
      fill_mat(127);
      fill_wt(-128);
      for (int d = 0; d < 16; d++) cls_wt[5*16+d] = 8'sd127;
      fill_bs(127);
      run("t4", 5, 3, -1, -1);

      // T7: single -1 in column 0 floors to feat0=-1, class 4 logit 1
      fill_mat(0);
      mat_in[0][0] = -8'sd1;
      fill_wt(0);
      cls_wt[4*16] = -8'sd1;
      fill_bs(0);
      run("t7", 4, 5, -1, -1);

      // T5: start while busy ignored, restart at 120
      fill_mat(-1);
      fill_wt(0);
      for (int d = 0; d < 16; d++) cls_wt[3*16+d] = -8'sd1;
      run("t5", 3, 4, 40, 120);

      // T6: reset at cycle 50 aborts run
      fill_mat(127);
      fill_wt(-128);
      for (int d = 0; d < 16; d++) cls_wt[5*16+d] = 8'sd127;
      fill_bs(127);
      cyc = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (cyc < 50) tick();
      rst = 1'b1;
      #1;
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_cls", int'(classifier), 0);
      chk("t6_rst_done", int'(done), 0);
      tick();
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (done) n++;
         tick();
      end
      chk("t6_no_done", n, 0);
      chk("t6_idle_cls", int'(classifier), 0);
      run("t6b", 5, 0, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
